// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: requests a word, presents it downstream, then pulses the PC unit.
// A fetch that sees no memory acknowledge within TIMEOUT cycles parks in FAULT until cleared.
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | imem_req high, waiting for imem_ack (bounded by TIMEOUT)
// ISSUE  | instr_valid high, waiting for instr_ready
// UPDATE | one-cycle pc_load with pc_src = captured branch_taken
// FAULT  | fetch timed out, waiting for fault_clr
module fetch_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        run,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic        fault_clr,
  output logic        imem_req,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        pc_load,
  output logic        pc_src,
  output logic        fault,
  output logic        busy
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_UPDATE,
    S_FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   instr_q;
  logic          br_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      // An acknowledge in the final allowed cycle still wins over the timeout.
      S_FETCH: begin
        if (imem_ack)              state_d = S_ISSUE;
        else if (cnt_q == CNT_MAX) state_d = S_FAULT;
      end
      S_ISSUE:  if (instr_ready) state_d = S_UPDATE;
      S_UPDATE: state_d = run ? S_FETCH : S_IDLE;
      S_FAULT:  if (fault_clr) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Counter only advances across ack-less FETCH cycles; any other path leaves it at zero.
      if (state_q == S_FETCH && !imem_ack && cnt_q != CNT_MAX)
        cnt_q <= cnt_q + 1'b1;
      else
        cnt_q <= '0;
      if (state_q == S_FETCH && imem_ack)
        instr_q <= imem_rdata;
      if (state_q == S_ISSUE && instr_ready)
        br_q <= branch_taken;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_ISSUE);
  assign pc_load     = (state_q == S_UPDATE);
  assign fault       = (state_q == S_FAULT);
  assign busy        = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_UPDATE);
  assign instr       = instr_q;
  assign pc_src      = br_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-built corner sequences,
// then randomized traffic compared against a cycle-level transaction model.
module tb_fetch_sequencer;
  localparam int TO = 16;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] IA = 32'h00500093;
  localparam logic [31:0] IB = 32'h00a00113;
  localparam logic [31:0] IC = 32'h00208463;
  localparam logic [31:0] ID = 32'hdeadbeef;
  localparam logic [31:0] IE = 32'h12345678;

  logic        clk = 1'b0;
  logic        areset, run, imem_ack, instr_ready, branch_taken, fault_clr;
  logic [31:0] imem_rdata;
  logic        imem_req, instr_valid, pc_load, pc_src, fault, busy;
  logic [31:0] instr;

  fetch_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .areset(areset), .run(run), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .fault_clr(fault_clr),
    .imem_req(imem_req), .instr(instr), .instr_valid(instr_valid),
    .pc_load(pc_load), .pc_src(pc_src), .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_req, input logic e_vld,
                         input logic e_ld, input logic e_src, input logic e_flt,
                         input logic e_bsy, input logic [31:0] e_ins);
    chk1({tag, ".imem_req"}, imem_req, e_req);
    chk1({tag, ".instr_valid"}, instr_valid, e_vld);
    chk1({tag, ".pc_load"}, pc_load, e_ld);
    chk1({tag, ".pc_src"}, pc_src, e_src);
    chk1({tag, ".fault"}, fault, e_flt);
    chk1({tag, ".busy"}, busy, e_bsy);
    chk32({tag, ".instr"}, instr, e_ins);
  endtask

  task automatic drive(input logic ar, input logic rn, input logic ack, input logic [31:0] rd,
                       input logic rdy, input logic br, input logic fc);
    areset = ar; run = rn; imem_ack = ack; imem_rdata = rd;
    instr_ready = rdy; branch_taken = br; fault_clr = fc;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic ar, rn, ack;
    logic [31:0] rd;
    logic rdy, br, fc;
    logic req, vld, ld, src, flt, bsy;
    logic [31:0] ins;
  } vec_t;

  vec_t tbl[13];

  // Transaction model: what the sequencer is doing right now, in plain terms.
  localparam int M_IDLE = 0, M_WAITMEM = 1, M_PRESENT = 2, M_COMMIT = 3, M_STUCK = 4;
  int          m_mode;
  int          m_waited;
  logic [31:0] m_instr;
  logic        m_src;

  task automatic model_step;
    if (areset) begin
      m_mode = M_IDLE; m_waited = 0; m_instr = '0; m_src = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: if (run) begin m_mode = M_WAITMEM; m_waited = 0; end
        M_WAITMEM: begin
          if (imem_ack) begin
            m_instr = imem_rdata; m_mode = M_PRESENT;
          end else begin
            m_waited = m_waited + 1;
            if (m_waited >= TO) m_mode = M_STUCK;
          end
        end
        M_PRESENT: if (instr_ready) begin m_src = branch_taken; m_mode = M_COMMIT; end
        M_COMMIT: begin m_mode = run ? M_WAITMEM : M_IDLE; m_waited = 0; end
        default: if (fault_clr) m_mode = M_IDLE;
      endcase
    end
  endtask

  initial begin
    int ack_div;
    drive(H, L, L, '0, L, L, L);

    tbl[0]  = '{H, L, L, IA, L, L, L,  L, L, L, L, L, L, 32'h0};
    tbl[1]  = '{L, H, H, IA, H, L, L,  H, L, L, L, L, H, 32'h0};
    tbl[2]  = '{L, H, H, IA, H, L, L,  L, H, L, L, L, H, IA};
    tbl[3]  = '{L, H, H, IB, H, L, L,  L, L, H, L, L, H, IA};
    tbl[4]  = '{L, H, H, IB, H, L, L,  H, L, L, L, L, H, IA};
    tbl[5]  = '{L, H, H, IB, H, L, L,  L, H, L, L, L, H, IB};
    tbl[6]  = '{L, H, H, IC, H, H, L,  L, L, H, H, L, H, IB};
    tbl[7]  = '{L, H, H, IC, H, L, L,  H, L, L, H, L, H, IB};
    tbl[8]  = '{L, H, H, IC, H, L, L,  L, H, L, H, L, H, IC};
    tbl[9]  = '{L, H, H, IC, H, L, H,  L, L, H, L, L, H, IC};
    tbl[10] = '{L, L, H, IA, H, H, L,  L, L, L, L, L, L, IC};
    tbl[11] = '{L, L, H, IA, H, H, H,  L, L, L, L, L, L, IC};
    tbl[12] = '{H, H, H, IA, H, H, H,  L, L, L, L, L, L, 32'h0};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].ar, tbl[i].rn, tbl[i].ack, tbl[i].rd, tbl[i].rdy, tbl[i].br, tbl[i].fc);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].req, tbl[i].vld, tbl[i].ld,
              tbl[i].src, tbl[i].flt, tbl[i].bsy, tbl[i].ins);
    end

    // Timeout: 16 FETCH cycles without ack, then FAULT; clear returns to IDLE.
    drive(H, L, L, '0, L, L, L); tick();
    drive(L, H, L, '0, L, L, L);
    for (int k = 1; k <= TO; k++) begin
      tick();
      chk1($sformatf("to_fetch%0d.imem_req", k), imem_req, H);
      chk1($sformatf("to_fetch%0d.fault", k), fault, L);
    end
    tick();
    chk_all("to_fault", L, L, L, L, H, L, 32'h0);
    tick();
    chk_all("to_fault_hold", L, L, L, L, H, L, 32'h0);
    drive(L, H, L, '0, L, L, H); tick();
    chk_all("to_clear", L, L, L, L, L, L, 32'h0);
    drive(L, H, L, '0, L, L, L); tick();
    chk_all("to_refetch", H, L, L, L, L, H, 32'h0);

    // Ack in the last allowed FETCH cycle wins; then ready held low for 5 cycles.
    drive(H, L, L, '0, L, L, L); tick();
    drive(L, H, L, '0, L, L, L);
    for (int k = 1; k <= TO; k++) tick();
    chk1("late_ack_pre.imem_req", imem_req, H);
    drive(L, H, H, ID, L, L, L); tick();
    chk_all("late_ack", L, H, L, L, L, H, ID);
    for (int k = 0; k < 5; k++) begin
      drive(L, H, H, IE, L, H, L); tick();
      chk_all($sformatf("stall%0d", k), L, H, L, L, L, H, ID);
    end
    drive(L, H, H, IE, H, H, L); tick();
    chk_all("stall_release", L, L, H, H, L, H, ID);
    drive(L, L, L, IE, H, L, L); tick();
    chk_all("stall_after", L, L, L, H, L, L, ID);

    // run dropped mid-fetch: instruction completes, single pc_load, then IDLE.
    drive(H, L, L, '0, L, L, L); tick();
    drive(L, H, L, '0, L, L, L); tick();
    drive(L, L, L, '0, L, L, L); tick();
    chk_all("drop_fetch", H, L, L, L, L, H, 32'h0);
    drive(L, L, H, IE, L, L, L); tick();
    chk_all("drop_issue", L, H, L, L, L, H, IE);
    drive(L, L, L, IA, H, L, L); tick();
    chk_all("drop_update", L, L, H, L, L, H, IE);
    tick();
    chk_all("drop_idle", L, L, L, L, L, L, IE);
    tick();
    chk_all("drop_idle2", L, L, L, L, L, L, IE);

    // Reset while presenting an instruction, and while faulted.
    drive(L, H, H, IB, L, H, L); tick(); tick();
    chk1("rst_issue_pre.instr_valid", instr_valid, H);
    drive(H, H, H, IC, H, H, H); tick();
    chk_all("rst_issue", L, L, L, L, L, L, 32'h0);
    drive(L, H, L, '0, L, L, L);
    for (int k = 0; k <= TO; k++) tick();
    chk1("rst_fault_pre.fault", fault, H);
    drive(H, H, H, IC, H, H, L); tick();
    chk_all("rst_fault", L, L, L, L, L, L, 32'h0);

    // Randomized traffic against the model.
    drive(H, L, L, '0, L, L, L);
    @(posedge clk); model_step(); @(negedge clk);
    ack_div = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 0) begin
        case ($urandom_range(0, 2))
          0: ack_div = 1;
          1: ack_div = 3;
          default: ack_div = 20;
        endcase
      end
      areset       = ($urandom_range(0, 199) == 0);
      run          = ($urandom_range(0, 7) != 0);
      imem_ack     = ($urandom_range(0, ack_div - 1) == 0);
      imem_rdata   = $urandom();
      instr_ready  = ($urandom_range(0, 2) != 0);
      branch_taken = ($urandom_range(0, 1) == 1);
      fault_clr    = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk_all($sformatf("rnd%0d", c), m_mode == M_WAITMEM, m_mode == M_PRESENT,
              m_mode == M_COMMIT, m_src, m_mode == M_STUCK,
              (m_mode == M_WAITMEM) || (m_mode == M_PRESENT) || (m_mode == M_COMMIT),
              m_instr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
